// File: rtl/cycle_ctrl.sv
// cycle_ctrl: instruction sequencing controller for a four-phase datapath.
// Tracks the external one-hot phase, decodes the latched opcode into datapath
// enables, handles HALT/go restart, counts retired instructions and traps
// any phase-sequence violation into a sticky error state.
//
// state  | meaning
// -------+-----------------------------------------------------------
// SYNC   | waiting for a FETCH phase to align with the cycle counter
// RUN    | executing instructions, enables decoded from ir_opcode
// HALTED | HALT retired; waiting for go, resumes at a WRITEBACK edge
// ERROR  | phase sequence violated; sticky until reset
module cycle_ctrl #(
  parameter int ICOUNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          cycle,
  input  logic [2:0]          opcode_in,
  input  logic                zero,
  input  logic                go,
  output logic                ir_load,
  output logic                pc_en,
  output logic                pc_branch,
  output logic                reg_we,
  output logic                alu_src_imm,
  output logic [1:0]          alu_op,
  output logic                halted,
  output logic                phase_err,
  output logic [ICOUNT_W-1:0] icount
);

  typedef enum logic [1:0] {SYNC, RUN, HALTED, ERROR} state_t;

  localparam logic [3:0] PH_FETCH  = 4'b0001;
  localparam logic [3:0] PH_DECODE = 4'b0010;
  localparam logic [3:0] PH_EXEC   = 4'b0100;
  localparam logic [3:0] PH_WB     = 4'b1000;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MULI = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_BNE  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [ICOUNT_W-1:0] ICOUNT_MAX = '1;

  state_t      state;
  logic [2:0]  ir_opcode;
  logic        taken;
  logic        go_pending;
  logic [3:0]  prev_phase;
  logic        prev_valid;
  logic        phase_bad;
  logic        run;
  logic        writes_reg;

  // A phase is bad if it is not one-hot, or (once a previous phase is
  // known) it is not the rotate-left successor of that phase.
  assign phase_bad = !$onehot(cycle) ||
                     (prev_valid && (cycle != {prev_phase[2:0], prev_phase[3]}));

  assign run        = (state == RUN);
  assign halted     = (state == HALTED);
  assign phase_err  = (state == ERROR);
  assign writes_reg = (ir_opcode == OP_ADD) || (ir_opcode == OP_ADDI) ||
                      (ir_opcode == OP_SUB) || (ir_opcode == OP_MULI);

  // Sequencing state, instruction register, branch/go flags and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SYNC;
      ir_opcode  <= OP_NOP;
      taken      <= 1'b0;
      go_pending <= 1'b0;
      icount     <= '0;
      prev_phase <= 4'b0000;
      prev_valid <= 1'b0;
    end else begin
      prev_phase <= cycle;
      prev_valid <= 1'b1;
      if (state != ERROR && phase_bad) begin
        state <= ERROR;
      end else begin
        case (state)
          SYNC: begin
            // The aligning FETCH also supplies the first instruction, so the
            // phases that follow it decode a real opcode, not a stale one.
            if (cycle == PH_FETCH) begin
              state     <= RUN;
              ir_opcode <= opcode_in;
              taken     <= 1'b0;
            end
          end
          RUN: begin
            case (cycle)
              PH_FETCH: begin
                ir_opcode <= opcode_in;
                taken     <= 1'b0;
              end
              PH_EXEC: begin
                taken <= ((ir_opcode == OP_BEQ) &&  zero) ||
                         ((ir_opcode == OP_BNE) && !zero);
              end
              PH_WB: begin
                if (ir_opcode == OP_HALT) begin
                  state <= HALTED;
                end else if (icount != ICOUNT_MAX) begin
                  icount <= icount + ICOUNT_W'(1);
                end
              end
              default: ;
            endcase
          end
          HALTED: begin
            if (go) go_pending <= 1'b1;
            if (cycle == PH_WB && go_pending) begin
              state      <= RUN;
              go_pending <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath enables follow the live phase so they line up with the
  // datapath's own phase-qualified registers.
  always_comb begin
    ir_load     = 1'b0;
    pc_en       = 1'b0;
    pc_branch   = 1'b0;
    reg_we      = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = 2'b00;
    if (run) begin
      ir_load     = (cycle == PH_FETCH);
      alu_src_imm = (ir_opcode == OP_ADDI) || (ir_opcode == OP_MULI);
      if (ir_opcode == OP_SUB)       alu_op = 2'b01;
      else if (ir_opcode == OP_MULI) alu_op = 2'b10;
      if (cycle == PH_WB) begin
        reg_we    = writes_reg;
        pc_en     = (ir_opcode != OP_HALT);
        pc_branch = taken;
      end
    end
  end

endmodule

// File: tb/tb_cycle_ctrl.sv
// Testbench for cycle_ctrl: table of per-cycle vectors with a scoreboard
// queue, plus a counter-saturation sequence on a narrow-counter instance.
module tb_cycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cycle;
  logic [2:0] opcode_in;
  logic       zero;
  logic       go;

  logic        ir_load, pc_en, pc_branch, reg_we, alu_src_imm, halted, phase_err;
  logic [1:0]  alu_op;
  logic [15:0] icount;

  logic        ir_load2, pc_en2, pc_branch2, reg_we2, alu_src_imm2, halted2, phase_err2;
  logic [1:0]  alu_op2;
  logic [1:0]  icount2;

  always #5 clk = ~clk;

  cycle_ctrl #(.ICOUNT_W(16)) dut (
    .clk(clk), .reset(reset), .cycle(cycle), .opcode_in(opcode_in),
    .zero(zero), .go(go), .ir_load(ir_load), .pc_en(pc_en),
    .pc_branch(pc_branch), .reg_we(reg_we), .alu_src_imm(alu_src_imm),
    .alu_op(alu_op), .halted(halted), .phase_err(phase_err), .icount(icount)
  );

  cycle_ctrl #(.ICOUNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cycle(cycle), .opcode_in(opcode_in),
    .zero(zero), .go(go), .ir_load(ir_load2), .pc_en(pc_en2),
    .pc_branch(pc_branch2), .reg_we(reg_we2), .alu_src_imm(alu_src_imm2),
    .alu_op(alu_op2), .halted(halted2), .phase_err(phase_err2), .icount(icount2)
  );

  // Output bit layout: {ir_load, pc_en, pc_branch, reg_we, alu_src_imm, alu_op[1:0], halted, phase_err}
  localparam logic [8:0] Z     = 9'h000;
  localparam logic [8:0] IL    = 9'h100;
  localparam logic [8:0] PE    = 9'h080;
  localparam logic [8:0] PB    = 9'h040;
  localparam logic [8:0] RW    = 9'h020;
  localparam logic [8:0] IM    = 9'h010;
  localparam logic [8:0] A_MUL = 9'h008;
  localparam logic [8:0] A_SUB = 9'h004;
  localparam logic [8:0] H     = 9'h002;
  localparam logic [8:0] E     = 9'h001;

  typedef struct {
    logic        rst;
    logic [3:0]  cyc;
    logic [2:0]  op;
    logic        z;
    logic        g;
    logic [8:0]  eo;
    logic [15:0] ic;
  } vec_t;

  typedef struct packed {
    logic [8:0]  o;
    logic [15:0] ic;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [8:0] got;
  assign got = {ir_load, pc_en, pc_branch, reg_we, alu_src_imm, alu_op, halted, phase_err};

  task automatic add(input logic r, input logic [3:0] c, input logic [2:0] o,
                     input logic zz, input logic gg, input logic [8:0] e, input int ic);
    vecs.push_back('{r, c, o, zz, gg, e, 16'(ic)});
  endtask

  task automatic drive(input logic r, input logic [3:0] c, input logic [2:0] o,
                       input logic zz, input logic gg);
    reset = r; cycle = c; opcode_in = o; zero = zz; go = gg;
  endtask

  initial begin
    drive(1'b1, 4'b0100, 3'b000, 1'b0, 1'b0);

    // reset released mid-instruction, then alignment and a NOP pass
    add(1, 4'b0100, 0, 0, 0, Z, 0);
    add(0, 4'b0100, 0, 0, 0, Z, 0);
    add(0, 4'b1000, 0, 0, 0, Z, 0);
    add(0, 4'b0001, 0, 0, 0, Z, 0);
    add(0, 4'b0010, 0, 0, 0, Z, 0);
    add(0, 4'b0100, 0, 0, 0, Z, 0);
    add(0, 4'b1000, 0, 0, 0, PE, 0);
    // ADDI
    add(0, 4'b0001, 2, 0, 0, IL, 1);
    add(0, 4'b0010, 0, 0, 0, IM, 1);
    add(0, 4'b0100, 0, 0, 0, IM, 1);
    add(0, 4'b1000, 0, 0, 0, RW | PE | IM, 1);
    // SUB
    add(0, 4'b0001, 3, 0, 0, IL | IM, 2);
    add(0, 4'b0010, 0, 0, 0, A_SUB, 2);
    add(0, 4'b0100, 0, 0, 0, A_SUB, 2);
    add(0, 4'b1000, 0, 0, 0, RW | PE | A_SUB, 2);
    // MULI
    add(0, 4'b0001, 4, 0, 0, IL | A_SUB, 3);
    add(0, 4'b0010, 0, 0, 0, IM | A_MUL, 3);
    add(0, 4'b0100, 0, 0, 0, IM | A_MUL, 3);
    add(0, 4'b1000, 0, 0, 0, RW | PE | IM | A_MUL, 3);
    // BEQ, zero=1 -> taken
    add(0, 4'b0001, 5, 0, 0, IL | IM | A_MUL, 4);
    add(0, 4'b0010, 0, 0, 0, Z, 4);
    add(0, 4'b0100, 0, 1, 0, Z, 4);
    add(0, 4'b1000, 0, 0, 0, PE | PB, 4);
    // BNE, zero=1 -> not taken
    add(0, 4'b0001, 6, 0, 0, IL, 5);
    add(0, 4'b0010, 0, 0, 0, Z, 5);
    add(0, 4'b0100, 0, 1, 0, Z, 5);
    add(0, 4'b1000, 0, 0, 0, PE, 5);
    // BNE, zero=0 -> taken
    add(0, 4'b0001, 6, 0, 0, IL, 6);
    add(0, 4'b0010, 0, 0, 0, Z, 6);
    add(0, 4'b0100, 0, 0, 0, Z, 6);
    add(0, 4'b1000, 0, 0, 0, PE | PB, 6);
    // HALT (go while running must be ignored)
    add(0, 4'b0001, 7, 0, 1, IL, 7);
    add(0, 4'b0010, 0, 0, 0, Z, 7);
    add(0, 4'b0100, 0, 0, 0, Z, 7);
    add(0, 4'b1000, 0, 0, 0, Z, 7);
    add(0, 4'b0001, 0, 0, 0, H, 7);
    add(0, 4'b0010, 0, 0, 0, H, 7);
    add(0, 4'b0100, 0, 0, 0, H, 7);
    add(0, 4'b1000, 0, 0, 0, H, 7);
    // go in DECODE, resume after next WRITEBACK
    add(0, 4'b0001, 0, 0, 0, H, 7);
    add(0, 4'b0010, 0, 0, 1, H, 7);
    add(0, 4'b0100, 0, 0, 0, H, 7);
    add(0, 4'b1000, 0, 0, 0, H, 7);
    add(0, 4'b0001, 1, 0, 0, IL, 7);
    add(0, 4'b0010, 0, 0, 0, Z, 7);
    add(0, 4'b0100, 0, 0, 0, Z, 7);
    add(0, 4'b1000, 0, 0, 0, RW | PE, 7);
    // reset mid-instruction abandons the ADD
    add(0, 4'b0001, 1, 0, 0, IL, 8);
    add(0, 4'b0010, 0, 0, 0, Z, 8);
    add(1, 4'b0100, 0, 0, 0, Z, 8);
    add(0, 4'b1000, 0, 0, 0, Z, 0);
    add(0, 4'b0001, 0, 0, 0, Z, 0);
    add(0, 4'b0010, 0, 0, 0, Z, 0);
    add(0, 4'b0100, 0, 0, 0, Z, 0);
    add(0, 4'b1000, 0, 0, 0, PE, 0);
    // FETCH then EXECUTE -> sticky error, icount frozen
    add(0, 4'b0001, 1, 0, 0, IL, 1);
    add(0, 4'b0100, 0, 0, 0, Z, 1);
    add(0, 4'b1000, 0, 0, 0, E, 1);
    add(0, 4'b0001, 0, 0, 1, E, 1);
    add(0, 4'b0010, 0, 0, 0, E, 1);
    add(0, 4'b0100, 0, 0, 0, E, 1);
    add(0, 4'b1000, 0, 0, 0, E, 1);
    add(1, 4'b0001, 0, 0, 0, E, 1);
    // all-zero phase -> error; reset overrides a simultaneous bad phase
    add(0, 4'b0001, 0, 0, 0, Z, 0);
    add(0, 4'b0010, 0, 0, 0, Z, 0);
    add(0, 4'b0000, 0, 0, 0, Z, 0);
    add(0, 4'b0001, 0, 0, 0, E, 0);
    add(1, 4'b0011, 0, 0, 0, E, 0);
    add(0, 4'b0001, 0, 0, 0, Z, 0);
    add(0, 4'b0010, 0, 0, 0, Z, 0);
    // bad rotation while still in SYNC
    add(1, 4'b0100, 0, 0, 0, Z, 0);
    add(0, 4'b0100, 0, 0, 0, Z, 0);
    add(0, 4'b0001, 0, 0, 0, Z, 0);
    add(0, 4'b0010, 0, 0, 0, E, 0);
    add(1, 4'b0001, 0, 0, 0, E, 0);

    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      exp_t e;
      exp_t a;
      @(posedge clk);
      #1;
      drive(vecs[i].rst, vecs[i].cyc, vecs[i].op, vecs[i].z, vecs[i].g);
      sb.push_back('{vecs[i].eo, vecs[i].ic});
      @(negedge clk);
      e = sb.pop_front();
      a = '{got, icount};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL vec%0d: got out=%h icount=%0d, want out=%h icount=%0d",
                 i, a.o, a.ic, e.o, e.ic);
      end
    end

    // narrow counter saturates: five retired ADDs read 1,2,3,3,3
    @(posedge clk);
    #1;
    for (int p = 0; p < 5; p++) begin
      exp_t e;
      logic [1:0] want;
      want = (p < 3) ? 2'(p + 1) : 2'd3;
      drive(1'b0, 4'b0001, 3'b001, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 4'b0010, 3'b000, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 4'b0100, 3'b000, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 4'b1000, 3'b000, 1'b0, 1'b0);
      sb.push_back('{Z, 16'(want)});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (icount2 !== e.ic[1:0]) begin
        errors++;
        $display("FAIL sat%0d: got icount=%0d, want icount=%0d", p, icount2, e.ic[1:0]);
      end
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
